// File: rtl/bus_master_arbiter_if.sv
// Signal bundle between the requesters / peripheral bus and the round-robin arbiter.
interface bus_master_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  // Requester side
  logic [NUM_MASTERS-1:0]        req;
  logic [NUM_MASTERS-1:0]        reqWrite;
  logic [NUM_MASTERS*ADDR_W-1:0] reqAddr;
  logic [NUM_MASTERS*DATA_W-1:0] reqData;
  logic [NUM_MASTERS-1:0]        grant;
  logic [NUM_MASTERS-1:0]        done;
  logic [DATA_W-1:0]             rdata;
  logic                          err;
  // Peripheral bus side
  logic [ADDR_W-1:0]             address;
  logic [DATA_W-1:0]             dataIn;
  logic                          read;
  logic                          write;
  logic [DATA_W-1:0]             dataOut;
  logic                          busReady;

  // Arbiter view: owns the bus strobes and the per-master completion signals
  modport master (
    input  req, reqWrite, reqAddr, reqData, dataOut, busReady,
    output grant, done, rdata, err, address, dataIn, read, write
  );

  // Requesters plus peripheral view
  modport slave (
    output req, reqWrite, reqAddr, reqData, dataOut, busReady,
    input  grant, done, rdata, err, address, dataIn, read, write
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one single-port peripheral bus between NUM_MASTERS
// requesters. The winner's command is latched, the strobe is held until busReady
// or a timeout, then a one-cycle done pulse (with err) goes back to the owner.
module bus_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_master_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [IDX_W:0]   NM_EXT   = (IDX_W + 1)'(NUM_MASTERS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_owner;
  logic [TMR_W-1:0]        r_timer;
  logic                    r_dir;
  logic [NUM_MASTERS-1:0]  r_grant;
  logic [NUM_MASTERS-1:0]  r_done;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_err;
  logic [ADDR_W-1:0]       r_address;
  logic [DATA_W-1:0]       r_data_in;
  logic                    r_read;
  logic                    r_write;

  state_t                  w_state_nx;
  logic [IDX_W-1:0]        w_ptr_nx;
  logic [IDX_W-1:0]        w_owner_nx;
  logic [TMR_W-1:0]        w_timer_nx;
  logic                    w_dir_nx;
  logic [NUM_MASTERS-1:0]  w_grant_nx;
  logic [NUM_MASTERS-1:0]  w_done_nx;
  logic [DATA_W-1:0]       w_rdata_nx;
  logic                    w_err_nx;
  logic [ADDR_W-1:0]       w_address_nx;
  logic [DATA_W-1:0]       w_data_in_nx;
  logic                    w_read_nx;
  logic                    w_write_nx;

  logic [2*NUM_MASTERS-1:0] w_req_rot;
  logic                     w_win_found;
  logic [IDX_W-1:0]         w_win_off;
  logic [IDX_W:0]           w_win_sum;
  logic [IDX_W-1:0]         w_win_idx;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_data;
  logic                     w_sel_dir;

  // Rotate the request vector so bit 0 is the master at the pointer.
  assign w_req_rot = {bus.req, bus.req} >> r_ptr;

  // Find the first requester at or above the pointer, wrapping modulo NUM_MASTERS.
  always_comb begin
    w_win_found = 1'b0;
    w_win_off   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!w_win_found && w_req_rot[k]) begin
        w_win_found = 1'b1;
        w_win_off   = IDX_W'(k);
      end else begin
        w_win_found = w_win_found;
      end
    end
    w_win_sum = {1'b0, r_ptr} + {1'b0, w_win_off};
    if (w_win_sum >= NM_EXT) begin
      w_win_idx = IDX_W'(w_win_sum - NM_EXT);
    end else begin
      w_win_idx = IDX_W'(w_win_sum);
    end
  end

  // Pick the winning master's command fields out of the packed request buses.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_dir  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (w_win_idx == IDX_W'(k)) begin
        w_sel_addr = bus.reqAddr[k*ADDR_W +: ADDR_W];
        w_sel_data = bus.reqData[k*DATA_W +: DATA_W];
        w_sel_dir  = bus.reqWrite[k];
      end else begin
        w_sel_dir  = w_sel_dir;
      end
    end
  end

  // Next-state and next-output logic. IDLE with a nonzero grant is the
  // one-cycle "owner latched" step before the strobe rises.
  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_owner_nx   = r_owner;
    w_timer_nx   = r_timer;
    w_dir_nx     = r_dir;
    w_grant_nx   = r_grant;
    w_done_nx    = '0;
    w_rdata_nx   = r_rdata;
    w_err_nx     = r_err;
    w_address_nx = r_address;
    w_data_in_nx = r_data_in;
    w_read_nx    = r_read;
    w_write_nx   = r_write;
    case (r_state)
      ST_IDLE: begin
        if (r_grant != '0) begin
          w_read_nx  = ~r_dir;
          w_write_nx = r_dir;
          w_timer_nx = '0;
          w_state_nx = ST_BUSY;
        end else if (w_win_found) begin
          w_grant_nx   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win_idx;
          w_owner_nx   = w_win_idx;
          w_address_nx = w_sel_addr;
          w_data_in_nx = w_sel_data;
          w_dir_nx     = w_sel_dir;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.busReady) begin
          if (r_read) begin
            w_rdata_nx = bus.dataOut;
          end else begin
            w_rdata_nx = r_rdata;
          end
          w_err_nx   = 1'b0;
          w_read_nx  = 1'b0;
          w_write_nx = 1'b0;
          w_done_nx  = r_grant;
          w_state_nx = ST_DONE;
        end else if (r_timer == TMR_LAST) begin
          w_err_nx   = 1'b1;
          w_read_nx  = 1'b0;
          w_write_nx = 1'b0;
          w_done_nx  = r_grant;
          w_state_nx = ST_DONE;
        end else begin
          w_timer_nx = r_timer + TMR_W'(1);
        end
      end
      ST_DONE: begin
        w_grant_nx = '0;
        if (r_owner == LAST_IDX) begin
          w_ptr_nx = '0;
        end else begin
          w_ptr_nx = r_owner + IDX_W'(1);
        end
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_grant_nx = '0;
        w_read_nx  = 1'b0;
        w_write_nx = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops strobes and grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_timer   <= '0;
      r_dir     <= 1'b0;
      r_grant   <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_address <= '0;
      r_data_in <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_owner   <= w_owner_nx;
      r_timer   <= w_timer_nx;
      r_dir     <= w_dir_nx;
      r_grant   <= w_grant_nx;
      r_done    <= w_done_nx;
      r_rdata   <= w_rdata_nx;
      r_err     <= w_err_nx;
      r_address <= w_address_nx;
      r_data_in <= w_data_in_nx;
      r_read    <= w_read_nx;
      r_write   <= w_write_nx;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
  assign bus.address = r_address;
  assign bus.dataIn  = r_data_in;
  assign bus.read    = r_read;
  assign bus.write   = r_write;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_bus_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk;
  logic reset;
  int cmp_count = 0;
  int fail_count = 0;

  // Reference model state: pointer and last successful read data
  int m_ptr = 0;
  logic [DW-1:0] m_rdata = '0;

  // Bus responder control: busReady in strobe cycle bus_lat+1, never if negative
  int bus_lat = -1;
  int rcnt = 0;

  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_data [N];
  logic          s_wr   [N];

  bus_master_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bif ();

  bus_master_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Peripheral model: counts strobe cycles and answers after the programmed latency
  initial begin
    bif.busReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.read || bif.write) begin
        rcnt = rcnt + 1;
        bif.busReady = (bus_lat >= 0) && (rcnt == bus_lat + 1);
      end else begin
        rcnt = 0;
        bif.busReady = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int m_pick(input logic [N-1:0] r);
    int w;
    w = -1;
    for (int k = N - 1; k >= 0; k--) begin
      if (r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    return w;
  endfunction

  function automatic int exp_cycles(input int lat);
    return (lat >= 0 && lat < TO) ? lat + 1 : TO;
  endfunction

  function automatic logic exp_err(input int lat);
    return !(lat >= 0 && lat < TO);
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      bif.reqAddr[i*AW +: AW] = s_addr[i];
      bif.reqData[i*DW +: DW] = s_data[i];
      bif.reqWrite[i]         = s_wr[i];
    end
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wr);
    s_addr[i] = a;
    s_data[i] = d;
    s_wr[i]   = wr;
    drive_fields();
  endtask

  task automatic randomize_masters();
    for (int i = 0; i < N; i++) begin
      s_addr[i] = $urandom;
      s_data[i] = $urandom;
      s_wr[i]   = 1'($urandom_range(0, 1));
    end
    drive_fields();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bif.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_ptr = 0;
    m_rdata = '0;
  endtask

  // Watch one transaction until its done pulse; records what the bus saw.
  task automatic observe(input bit scramble,
                         output logic [N-1:0] o_grant, output logic o_rd, output logic o_wr,
                         output logic [AW-1:0] o_addr, output logic [DW-1:0] o_data,
                         output int o_cycles, output int o_latency, output bit o_stable,
                         output logic [N-1:0] o_done, output logic o_err, output logic [DW-1:0] o_rdata,
                         output bit o_strobe_at_done, output bit o_expired);
    int c;
    o_grant = '0; o_rd = 1'b0; o_wr = 1'b0; o_addr = '0; o_data = '0;
    o_cycles = 0; o_latency = 0; o_stable = 1'b1; o_done = '0; o_err = 1'b0;
    o_rdata = '0; o_strobe_at_done = 1'b0; o_expired = 1'b1; c = 0;
    while (o_expired && c < 200) begin
      @(negedge clk);
      c = c + 1;
      if (bif.read || bif.write) begin
        if (o_cycles == 0) begin
          o_grant = bif.grant; o_rd = bif.read; o_wr = bif.write;
          o_addr = bif.address; o_data = bif.dataIn; o_latency = c;
          if (scramble) begin
            for (int i = 0; i < N; i++) begin
              bif.reqAddr[i*AW +: AW] = $urandom;
              bif.reqData[i*DW +: DW] = $urandom;
            end
            bif.reqWrite = N'($urandom);
            bif.req      = N'($urandom);
          end
        end else if (bif.grant !== o_grant || bif.read !== o_rd || bif.write !== o_wr ||
                     bif.address !== o_addr || bif.dataIn !== o_data) begin
          o_stable = 1'b0;
        end
        o_cycles = o_cycles + 1;
      end
      if (bif.done != '0) begin
        o_done = bif.done; o_err = bif.err; o_rdata = bif.rdata;
        o_strobe_at_done = bif.read | bif.write;
        o_expired = 1'b0;
      end
    end
  endtask

  logic [N-1:0] g, dn;
  logic rd, wr, er;
  logic [AW-1:0] ad;
  logic [DW-1:0] dt, rdat;
  int cyc, lat_n;
  bit stab, sad, expd;

  task automatic test_reset();
    reset = 1'b1;
    bif.req = '0;
    repeat (2) @(negedge clk);
    cmp_count++; if (bif.grant !== '0) begin fail_count++; $display("FAIL reset_grant: got %b exp 0", bif.grant); end
    cmp_count++; if (bif.done !== '0) begin fail_count++; $display("FAIL reset_done: got %b exp 0", bif.done); end
    cmp_count++; if (bif.rdata !== '0) begin fail_count++; $display("FAIL reset_rdata: got %h exp 0", bif.rdata); end
    cmp_count++; if (bif.err !== 1'b0) begin fail_count++; $display("FAIL reset_err: got %b exp 0", bif.err); end
    cmp_count++; if (bif.address !== '0) begin fail_count++; $display("FAIL reset_address: got %h exp 0", bif.address); end
    cmp_count++; if (bif.dataIn !== '0) begin fail_count++; $display("FAIL reset_dataIn: got %h exp 0", bif.dataIn); end
    cmp_count++; if (bif.read !== 1'b0 || bif.write !== 1'b0) begin fail_count++; $display("FAIL reset_strobes: got r=%b w=%b exp 0", bif.read, bif.write); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp_count++; if (bif.grant !== '0) begin fail_count++; $display("FAIL idle_grant: got %b exp 0", bif.grant); end
    m_ptr = 0;
    m_rdata = '0;
  endtask

  task automatic test_single_read();
    int w;
    set_master(2, 32'h8000_0010, 32'h0BAD_F00D, 1'b0);
    bus_lat = 3;
    bif.dataOut = 32'hDEAD_BEEF;
    bif.req = 4'b0100;
    w = m_pick(bif.req);
    observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
    bif.req = '0;
    cmp_count++; if (expd) begin fail_count++; $display("FAIL rd_expired: got no done exp done"); end
    cmp_count++; if (g !== onehot(w)) begin fail_count++; $display("FAIL rd_grant: got %b exp %b", g, onehot(w)); end
    cmp_count++; if (rd !== 1'b1 || wr !== 1'b0) begin fail_count++; $display("FAIL rd_strobe: got r=%b w=%b exp r=1 w=0", rd, wr); end
    cmp_count++; if (lat_n != 2) begin fail_count++; $display("FAIL rd_latency: got %0d exp 2", lat_n); end
    cmp_count++; if (cyc != exp_cycles(3)) begin fail_count++; $display("FAIL rd_cycles: got %0d exp %0d", cyc, exp_cycles(3)); end
    cmp_count++; if (ad !== 32'h8000_0010 || !stab) begin fail_count++; $display("FAIL rd_addr: got %h stable=%b exp 80000010", ad, stab); end
    cmp_count++; if (dn !== onehot(w)) begin fail_count++; $display("FAIL rd_done: got %b exp %b", dn, onehot(w)); end
    cmp_count++; if (rdat !== 32'hDEAD_BEEF) begin fail_count++; $display("FAIL rd_rdata: got %h exp deadbeef", rdat); end
    cmp_count++; if (er !== 1'b0) begin fail_count++; $display("FAIL rd_err: got %b exp 0", er); end
    cmp_count++; if (sad) begin fail_count++; $display("FAIL rd_strobe_at_done: got 1 exp 0"); end
    m_ptr = (w + 1) % N;
    m_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int w;
    set_master(0, 32'h4000_0000, 32'h1234_5678, 1'b1);
    bus_lat = 2;
    bif.dataOut = 32'hCAFE_0001;
    bif.req = 4'b0001;
    w = m_pick(bif.req);
    observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
    bif.req = '0;
    cmp_count++; if (wr !== 1'b1 || rd !== 1'b0) begin fail_count++; $display("FAIL wr_strobe: got r=%b w=%b exp r=0 w=1", rd, wr); end
    cmp_count++; if (ad !== 32'h4000_0000 || dt !== 32'h1234_5678) begin fail_count++; $display("FAIL wr_fields: got %h/%h exp 40000000/12345678", ad, dt); end
    cmp_count++; if (!stab || cyc != exp_cycles(2)) begin fail_count++; $display("FAIL wr_hold: got stable=%b cycles=%0d exp 1/%0d", stab, cyc, exp_cycles(2)); end
    cmp_count++; if (dn !== onehot(w)) begin fail_count++; $display("FAIL wr_done: got %b exp %b", dn, onehot(w)); end
    cmp_count++; if (rdat !== m_rdata) begin fail_count++; $display("FAIL wr_rdata: got %h exp %h", rdat, m_rdata); end
    m_ptr = (w + 1) % N;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int w;
    apply_reset();
    randomize_masters();
    bus_lat = 0;
    bif.dataOut = $urandom;
    bif.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = m_pick(bif.req);
      observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
      if (t == 4) bif.req = '0;
      cmp_count++; if (dn !== onehot(w) || g !== onehot(w)) begin fail_count++; $display("FAIL rr_order[%0d]: got grant %b done %b exp %b", t, g, dn, onehot(w)); end
      cmp_count++; if (ad !== s_addr[w] || wr !== s_wr[w] || cyc != 1 || sad) begin fail_count++; $display("FAIL rr_txn[%0d]: got addr %h wr %b cyc %0d exp %h %b 1", t, ad, wr, cyc, s_addr[w], s_wr[w]); end
      if (!s_wr[w]) m_rdata = bif.dataOut;
      m_ptr = (w + 1) % N;
      cmp_count++; if (rdat !== m_rdata || er !== 1'b0) begin fail_count++; $display("FAIL rr_rdata[%0d]: got %h err %b exp %h 0", t, rdat, er, m_rdata); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_new_pointer();
    int w;
    bus_lat = 1;
    bif.req = 4'b0100;
    w = m_pick(bif.req);
    observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
    cmp_count++; if (dn !== onehot(w)) begin fail_count++; $display("FAIL np_m2_done: got %b exp %b", dn, onehot(w)); end
    if (!s_wr[w]) m_rdata = bif.dataOut;
    m_ptr = (w + 1) % N;
    bif.req = 4'b1010;
    for (int t = 0; t < 2; t++) begin
      w = m_pick(bif.req);
      observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
      if (t == 1) bif.req = '0;
      cmp_count++; if (dn !== onehot(w)) begin fail_count++; $display("FAIL np_order[%0d]: got %b exp %b", t, dn, onehot(w)); end
      if (!s_wr[w]) m_rdata = bif.dataOut;
      m_ptr = (w + 1) % N;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int w;
    set_master(1, 32'h0000_1000, 32'h0, 1'b0);
    bus_lat = -1;
    bif.dataOut = 32'h5555_AAAA;
    bif.req = 4'b0010;
    w = m_pick(bif.req);
    observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
    bif.req = '0;
    cmp_count++; if (cyc != TO || sad) begin fail_count++; $display("FAIL to_cycles: got %0d exp %0d", cyc, TO); end
    cmp_count++; if (er !== 1'b1 || dn !== onehot(w)) begin fail_count++; $display("FAIL to_err: got err %b done %b exp 1 %b", er, dn, onehot(w)); end
    cmp_count++; if (rdat !== m_rdata) begin fail_count++; $display("FAIL to_rdata: got %h exp %h", rdat, m_rdata); end
    m_ptr = (w + 1) % N;
    repeat (2) @(negedge clk);
    bus_lat = 2;
    bif.dataOut = 32'h0F0F_1234;
    bif.req = 4'b0010;
    w = m_pick(bif.req);
    observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
    bif.req = '0;
    cmp_count++; if (er !== 1'b0 || rdat !== 32'h0F0F_1234 || dn !== onehot(w)) begin fail_count++; $display("FAIL to_recover: got err %b rdata %h done %b exp 0 0f0f1234 %b", er, rdat, dn, onehot(w)); end
    m_rdata = 32'h0F0F_1234;
    m_ptr = (w + 1) % N;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ready_on_last_cycle();
    int w;
    bus_lat = TO - 1;
    bif.dataOut = 32'h7777_0016;
    bif.req = 4'b0010;
    w = m_pick(bif.req);
    observe(1'b0, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
    bif.req = '0;
    cmp_count++; if (er !== 1'b0 || cyc != TO) begin fail_count++; $display("FAIL last_ready: got err %b cycles %0d exp 0 %0d", er, cyc, TO); end
    cmp_count++; if (rdat !== 32'h7777_0016) begin fail_count++; $display("FAIL last_ready_rdata: got %h exp 77770016", rdat); end
    m_rdata = 32'h7777_0016;
    m_ptr = (w + 1) % N;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int c;
    int dcount;
    set_master(3, 32'h9000_0000, 32'h0, 1'b0);
    bus_lat = -1;
    bif.req = 4'b1000;
    c = 0;
    while (!bif.read && c < 10) begin
      @(negedge clk);
      c = c + 1;
    end
    cmp_count++; if (bif.read !== 1'b1) begin fail_count++; $display("FAIL rst_mid_start: got read %b exp 1", bif.read); end
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    cmp_count++; if (bif.read !== 1'b0 || bif.grant !== '0) begin fail_count++; $display("FAIL rst_mid_async: got read %b grant %b exp 0 0", bif.read, bif.grant); end
    @(negedge clk);
    bif.req = '0;
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.done != '0 || bif.read || bif.write) dcount = dcount + 1;
    end
    cmp_count++; if (dcount != 0) begin fail_count++; $display("FAIL rst_mid_nodone: got %0d active cycles exp 0", dcount); end
    cmp_count++; if (bif.rdata !== '0 || bif.err !== 1'b0) begin fail_count++; $display("FAIL rst_mid_state: got rdata %h err %b exp 0 0", bif.rdata, bif.err); end
    m_ptr = 0;
    m_rdata = '0;
  endtask

  task automatic test_random();
    int w;
    int lat;
    logic [DW-1:0] word;
    for (int t = 0; t < 40; t++) begin
      randomize_masters();
      lat = int'($urandom_range(0, 20)) - 1;
      word = $urandom;
      bus_lat = lat;
      bif.dataOut = word;
      bif.req = N'($urandom_range(1, (1 << N) - 1));
      w = m_pick(bif.req);
      observe(1'b1, g, rd, wr, ad, dt, cyc, lat_n, stab, dn, er, rdat, sad, expd);
      cmp_count++; if (expd || dn !== onehot(w) || g !== onehot(w)) begin fail_count++; $display("FAIL rnd_winner[%0d]: got grant %b done %b exp %b", t, g, dn, onehot(w)); end
      cmp_count++; if (ad !== s_addr[w] || dt !== s_data[w] || !stab) begin fail_count++; $display("FAIL rnd_fields[%0d]: got %h/%h stable %b exp %h/%h", t, ad, dt, stab, s_addr[w], s_data[w]); end
      cmp_count++; if (wr !== s_wr[w] || rd !== !s_wr[w] || sad) begin fail_count++; $display("FAIL rnd_dir[%0d]: got r=%b w=%b exp w=%b", t, rd, wr, s_wr[w]); end
      cmp_count++; if (cyc != exp_cycles(lat) || er !== exp_err(lat)) begin fail_count++; $display("FAIL rnd_timing[%0d]: got cyc %0d err %b exp %0d %b", t, cyc, er, exp_cycles(lat), exp_err(lat)); end
      if (!s_wr[w] && !exp_err(lat)) m_rdata = word;
      m_ptr = (w + 1) % N;
      cmp_count++; if (rdat !== m_rdata) begin fail_count++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", t, rdat, m_rdata); end
    end
    bif.req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bif.req = '0;
    bif.dataOut = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0;
      s_data[i] = '0;
      s_wr[i] = 1'b0;
    end
    drive_fields();
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_new_pointer();
    test_timeout();
    test_ready_on_last_cycle();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end
endmodule
